// File: rtl/fetch6809.sv
// fetch6809 - instruction-fetch and vector sequencer for the m6809 core.
//
// Owns the memory bus from reset through each opcode fetch. It fetches one of
// the eight vectors, folds page-prefix bytes (0x10/0x11) into a single decoded
// opcode, offers it to execute over a valid/ready handshake, and then releases
// the bus until execute returns control with the next PC.
//
// Optional feature macro: FETCH6809_PREFIX_EN
//   defined   : 0x10/0x11 prefixes are merged (PREFIX state present)
//   undefined : every byte is issued as a plain opcode, ir_page tied to 0
//
// Parameters
//   ADDR_W     address / PC width
//   VEC_BASE   base of the vector table (vector n at VEC_BASE+2n, +2n+1)
//   RESET_IDLE idle bus cycles after reset release (1..15)
//
// Ports
//   clk, reset_b           clock (rising edge), async active-low reset
//   addr, rd               registered bus address and read strobe
//   data_in                read data for addr, sampled at end of cycle
//   ir_valid, ir_ready     opcode handshake to execute
//   ir_op, ir_page, ir_pc  decoded opcode, prefix page, instruction address
//   pc                     address following the last fetched byte
//   resume, resume_pc      execute finished; next fetch address
//   vec_req, vec_sel       level vector request and index
//   vec_ack                one-cycle pulse when the vector PC is loaded
//   halt_b, halted         halt request (low) and parked indication
module fetch6809 #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(16'hFFF0),
  parameter int                RESET_IDLE = 1
) (
  input  logic              clk,
  input  logic              reset_b,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  input  logic [7:0]        data_in,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [7:0]        ir_op,
  output logic [1:0]        ir_page,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [ADDR_W-1:0] pc,
  input  logic              resume,
  input  logic [ADDR_W-1:0] resume_pc,
  input  logic              vec_req,
  input  logic [2:0]        vec_sel,
  output logic              vec_ack,
  input  logic              halt_b,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_RESET,
    S_VEC_HI,
    S_VEC_LO,
    S_FETCH,
`ifdef FETCH6809_PREFIX_EN
    S_PREFIX,
`endif
    S_ISSUE,
    S_HOLD,
    S_HALT
  } state_t;

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE - 1);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt;
  logic [2:0]        r_vec, w_vec_nxt;
  logic              r_rst_entry, w_rst_entry_nxt;
  logic [7:0]        r_vec_hi;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_ir_pc, w_ir_pc_nxt;
  logic [7:0]        r_ir_op, w_ir_op_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_rd, r_ir_valid, r_vec_ack, r_halted;
`ifdef FETCH6809_PREFIX_EN
  logic [1:0]        r_ir_page, w_ir_page_nxt;
`endif

  // Vector table address, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] vec_addr(input logic [2:0] v);
    return VEC_BASE + ADDR_W'({v, 1'b0});
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_vec_nxt       = r_vec;
    w_rst_entry_nxt = r_rst_entry;
    w_pc_nxt        = r_pc;
    w_ir_pc_nxt     = r_ir_pc;
    w_ir_op_nxt     = r_ir_op;
`ifdef FETCH6809_PREFIX_EN
    w_ir_page_nxt   = r_ir_page;
`endif
    case (r_state)
      S_RESET: begin
        if (r_cnt == IDLE_LAST) begin
          w_state_nxt     = S_VEC_HI;
          w_vec_nxt       = 3'd7;
          w_rst_entry_nxt = 1'b1;
        end
      end
      S_VEC_HI: w_state_nxt = S_VEC_LO;
      S_VEC_LO: begin
        w_pc_nxt    = ADDR_W'({r_vec_hi, data_in});
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_ir_pc_nxt = r_pc;
        w_pc_nxt    = r_pc + 1'b1;
`ifdef FETCH6809_PREFIX_EN
        if (data_in == 8'h10 || data_in == 8'h11) begin
          w_ir_page_nxt = (data_in == 8'h10) ? 2'd1 : 2'd2;
          w_state_nxt   = S_PREFIX;
        end else begin
          w_ir_page_nxt = 2'd0;
          w_ir_op_nxt   = data_in;
          w_state_nxt   = S_ISSUE;
        end
`else
        w_ir_op_nxt = data_in;
        w_state_nxt = S_ISSUE;
`endif
      end
`ifdef FETCH6809_PREFIX_EN
      S_PREFIX: begin
        w_pc_nxt = r_pc + 1'b1;
        // Repeated prefixes: the last one seen selects the page.
        if (data_in == 8'h10 || data_in == 8'h11) begin
          w_ir_page_nxt = (data_in == 8'h10) ? 2'd1 : 2'd2;
        end else begin
          w_ir_op_nxt = data_in;
          w_state_nxt = S_ISSUE;
        end
      end
`endif
      S_ISSUE: begin
        if (ir_ready) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (resume) begin
          w_pc_nxt = resume_pc;
          if (!halt_b) begin
            w_state_nxt = S_HALT;
          end else if (vec_req) begin
            w_state_nxt     = S_VEC_HI;
            w_vec_nxt       = vec_sel;
            w_rst_entry_nxt = 1'b0;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (halt_b) begin
          if (vec_req) begin
            w_state_nxt     = S_VEC_HI;
            w_vec_nxt       = vec_sel;
            w_rst_entry_nxt = 1'b0;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Bus outputs are registered from the next-state decode so that addr/rd
  // change only on the clock edge that enters the state they belong to.
  always_comb begin
    w_addr_nxt = r_addr;
    case (w_state_nxt)
      S_RESET:  w_addr_nxt = vec_addr(3'd7);
      S_VEC_HI: w_addr_nxt = vec_addr(w_vec_nxt);
      S_VEC_LO: w_addr_nxt = vec_addr(w_vec_nxt) + 1'b1;
      S_FETCH:  w_addr_nxt = w_pc_nxt;
`ifdef FETCH6809_PREFIX_EN
      S_PREFIX: w_addr_nxt = w_pc_nxt;
`endif
      default:  w_addr_nxt = r_addr;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= S_RESET;
      r_cnt       <= 4'd0;
      r_vec       <= 3'd7;
      r_rst_entry <= 1'b1;
      r_vec_hi    <= 8'd0;
      r_pc        <= '0;
      r_ir_pc     <= '0;
      r_ir_op     <= 8'd0;
      r_addr      <= vec_addr(3'd7);
      r_rd        <= 1'b0;
      r_ir_valid  <= 1'b0;
      r_vec_ack   <= 1'b0;
      r_halted    <= 1'b0;
`ifdef FETCH6809_PREFIX_EN
      r_ir_page   <= 2'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= (r_state == S_RESET && w_state_nxt == S_RESET) ? r_cnt + 4'd1 : 4'd0;
      r_vec       <= w_vec_nxt;
      r_rst_entry <= w_rst_entry_nxt;
      if (r_state == S_VEC_HI) r_vec_hi <= data_in;
      r_pc        <= w_pc_nxt;
      r_ir_pc     <= w_ir_pc_nxt;
      r_ir_op     <= w_ir_op_nxt;
      r_addr      <= w_addr_nxt;
      r_rd        <= (w_state_nxt == S_VEC_HI) || (w_state_nxt == S_VEC_LO) ||
`ifdef FETCH6809_PREFIX_EN
                     (w_state_nxt == S_PREFIX) ||
`endif
                     (w_state_nxt == S_FETCH);
      r_ir_valid  <= (w_state_nxt == S_ISSUE);
      // The reset-vector load is not acknowledged to the interrupt logic.
      r_vec_ack   <= (w_state_nxt == S_VEC_LO) && !w_rst_entry_nxt;
      r_halted    <= (w_state_nxt == S_HALT);
`ifdef FETCH6809_PREFIX_EN
      r_ir_page   <= w_ir_page_nxt;
`endif
    end
  end

  assign addr     = r_addr;
  assign rd       = r_rd;
  assign ir_valid = r_ir_valid;
  assign ir_op    = r_ir_op;
  assign ir_pc    = r_ir_pc;
  assign pc       = r_pc;
  assign vec_ack  = r_vec_ack;
  assign halted   = r_halted;
`ifdef FETCH6809_PREFIX_EN
  assign ir_page  = r_ir_page;
`else
  assign ir_page  = 2'd0;
`endif

endmodule

// File: tb/tb_fetch6809.sv
module tb_fetch6809;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [15:0] addr;
  logic        rd;
  logic [7:0]  data_in;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_op;
  logic [1:0]  ir_page;
  logic [15:0] ir_pc;
  logic [15:0] pc;
  logic        resume;
  logic [15:0] resume_pc;
  logic        vec_req;
  logic [2:0]  vec_sel;
  logic        vec_ack;
  logic        halt_b;
  logic        halted;

  logic [7:0]  mem [0:65535];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  assign data_in = mem[addr];

  fetch6809 dut (
    .clk(clk), .reset_b(reset_b), .addr(addr), .rd(rd), .data_in(data_in),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_op(ir_op), .ir_page(ir_page),
    .ir_pc(ir_pc), .pc(pc), .resume(resume), .resume_pc(resume_pc),
    .vec_req(vec_req), .vec_sel(vec_sel), .vec_ack(vec_ack),
    .halt_b(halt_b), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic handshake();
    ir_ready = 1'b1;
    step();
    check("valid_drop", ir_valid, 1'b0);
    ir_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h34; mem[16'h1234] = 8'h86;
    mem[16'h2000] = 8'h10; mem[16'h2001] = 8'h10; mem[16'h2002] = 8'h8E;
    mem[16'hFFF8] = 8'h40; mem[16'hFFF9] = 8'h00; mem[16'h4000] = 8'h12;
    mem[16'hFFFC] = 8'h60; mem[16'hFFFD] = 8'h00; mem[16'h6000] = 8'h4F;
    mem[16'h0000] = 8'hA3;
    reset_b = 1'b0; ir_ready = 1'b0; resume = 1'b0; resume_pc = 16'h0;
    vec_req = 1'b0; vec_sel = 3'd0; halt_b = 1'b1;

    // Reset state
    step(); step();
    check("rst_addr", addr, 16'hFFFE);
    check("rst_rd", rd, 1'b0);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_op", ir_op, 8'h00);
    check("rst_page", ir_page, 2'd0);
    check("rst_irpc", ir_pc, 16'h0000);
    check("rst_pc", pc, 16'h0000);
    check("rst_ack", vec_ack, 1'b0);
    check("rst_halted", halted, 1'b0);

    // Reset vector fetch
    reset_b = 1'b1;
    check("c0_addr", addr, 16'hFFFE);
    step();
    check("c1_addr", addr, 16'hFFFE);
    check("c1_rd", rd, 1'b1);
    step();
    check("c2_addr", addr, 16'hFFFF);
    check("c2_ack", vec_ack, 1'b0);
    step();
    check("c3_addr", addr, 16'h1234);
    check("c3_rd", rd, 1'b1);
    step();
    check("c4_valid", ir_valid, 1'b1);
    check("c4_op", ir_op, 8'h86);
    check("c4_page", ir_page, 2'd0);
    check("c4_irpc", ir_pc, 16'h1234);
    check("c4_pc", pc, 16'h1235);
    check("c4_rd", rd, 1'b0);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", ir_valid, 1'b1);
      check("bp_rd", rd, 1'b0);
      check("bp_op", ir_op, 8'h86);
      check("bp_irpc", ir_pc, 16'h1234);
      check("bp_pc", pc, 16'h1235);
    end
    handshake();

    // Prefix merge
    resume = 1'b1; resume_pc = 16'h2000;
    step();
    resume = 1'b0;
    check("pf_addr", addr, 16'h2000);
    check("pf_rd", rd, 1'b1);
`ifdef FETCH6809_PREFIX_EN
    step(); step(); step();
    check("pf_valid", ir_valid, 1'b1);
    check("pf_page", ir_page, 2'd1);
    check("pf_op", ir_op, 8'h8E);
    check("pf_irpc", ir_pc, 16'h2000);
    check("pf_pc", pc, 16'h2003);
`else
    step();
    check("pf_valid", ir_valid, 1'b1);
    check("pf_page", ir_page, 2'd0);
    check("pf_op", ir_op, 8'h10);
    check("pf_irpc", ir_pc, 16'h2000);
    check("pf_pc", pc, 16'h2001);
`endif
    handshake();

    // Vector entry (IRQ)
    vec_req = 1'b1; vec_sel = 3'd4; resume = 1'b1; resume_pc = 16'h3000;
    step();
    resume = 1'b0;
    check("ve_hi_addr", addr, 16'hFFF8);
    check("ve_hi_ack", vec_ack, 1'b0);
    step();
    check("ve_lo_addr", addr, 16'hFFF9);
    check("ve_lo_ack", vec_ack, 1'b1);
    vec_req = 1'b0;
    step();
    check("ve_fetch", addr, 16'h4000);
    check("ve_ack_drop", vec_ack, 1'b0);
    step();
    check("ve_op", ir_op, 8'h12);
    check("ve_pc", pc, 16'h4001);
    handshake();

    // Halt, then leave through NMI
    halt_b = 1'b0; resume = 1'b1; resume_pc = 16'h5000;
    step();
    resume = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ht_halted", halted, 1'b1);
      check("ht_rd", rd, 1'b0);
      step();
    end
    halt_b = 1'b1; vec_req = 1'b1; vec_sel = 3'd6;
    step();
    check("ht_vhi", addr, 16'hFFFC);
    check("ht_unhalt", halted, 1'b0);
    step();
    check("ht_vlo", addr, 16'hFFFD);
    vec_req = 1'b0;
    step();
    check("ht_fetch", addr, 16'h6000);
    step();
    check("ht_op", ir_op, 8'h4F);
    handshake();

    // PC wrap
    mem[16'hFFFF] = 8'h11;
    resume = 1'b1; resume_pc = 16'hFFFF;
    step();
    resume = 1'b0;
    check("wr_addr", addr, 16'hFFFF);
`ifdef FETCH6809_PREFIX_EN
    step();
    check("wr_pf_addr", addr, 16'h0000);
    step();
    check("wr_page", ir_page, 2'd2);
    check("wr_op", ir_op, 8'hA3);
    check("wr_irpc", ir_pc, 16'hFFFF);
    check("wr_pc", pc, 16'h0001);
`else
    step();
    check("wr_page", ir_page, 2'd0);
    check("wr_op", ir_op, 8'h11);
    check("wr_irpc", ir_pc, 16'hFFFF);
    check("wr_pc", pc, 16'h0000);
`endif
    handshake();

    // Reset in the middle of an instruction fetch
    resume = 1'b1; resume_pc = 16'hFFFF;
    step();
    resume = 1'b0;
    step();
    #1 reset_b = 1'b0;
    #1;
    check("mr_valid", ir_valid, 1'b0);
    check("mr_addr", addr, 16'hFFFE);
    check("mr_rd", rd, 1'b0);
    step();
    reset_b = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch6809.md
# fetch6809

Parametrised instruction-fetch and vector sequencer for the m6809 core. It owns the memory bus from reset through each opcode fetch. It fetches any of the eight hardware/software vectors, collects page-prefix bytes (0x10/0x11) into a single decoded opcode, and issues it to the execute stage over a valid/ready handshake. After issue it releases the bus until execute hands back control with the next PC.

## Interface
- ADDR_W, 16, address/PC width
- VEC_BASE, 16'hFFF0 (ADDR_W bits), base of vector table; vector n lives at VEC_BASE+2n (MSB) and VEC_BASE+2n+1 (LSB)
- RESET_IDLE, 1, idle bus cycles after reset release before the reset-vector fetch (1..15)
- clk  in  1  clock, rising edge
- reset_b  in  1  reset, asynchronous, active-low
- addr  out  ADDR_W  registered bus address
- rd  out  1  registered read strobe; 0 means the bus is released
- data_in  in  8  read data for the current addr, sampled at the end of the cycle
- ir_valid  out  1  decoded opcode available
- ir_ready  in  1  execute stage accepts the opcode
- ir_op  out  8  opcode byte (after any prefix)
- ir_page  out  2  0 none, 1 prefix 0x10, 2 prefix 0x11
- ir_pc  out  ADDR_W  address of the first byte of the instruction (prefix included)
- pc  out  ADDR_W  address following the last fetched byte
- resume  in  1  one-cycle pulse from execute: instruction finished
- resume_pc  in  ADDR_W  next fetch address, loaded on resume
- vec_req  in  1  level vector request, held until vec_ack
- vec_sel  in  3  vector index (7 reset, 6 NMI, 5 SWI, 4 IRQ, 3 FIRQ, 2 SWI2, 1 SWI3)
- vec_ack  out  1  one-cycle pulse when the vector PC is loaded
- halt_b  in  1  low: stop at the next instruction boundary
- halted  out  1  block parked in HALT

## Operation
- States: RESET, VEC_HI, VEC_LO, FETCH, PREFIX, ISSUE, HOLD, HALT.
- RESET
  - rd=0; addr=VEC_BASE+14; a 4-bit counter runs for RESET_IDLE cycles.
  - Then VEC_HI with the latched vector index forced to 7.
- VEC_HI
  - addr=VEC_BASE+2·vec; rd=1; MSB captured into pc[15:8].
- VEC_LO
  - addr=VEC_BASE+2·vec+1; LSB captured; pc={hi,lo}; vec_ack=1 for this cycle (not on reset entry); then FETCH.
- FETCH
  - addr=pc; rd=1; ir_pc<=pc; pc<=pc+1.
  - Byte 0x10/0x11 → PREFIX with ir_page=1/2.
  - Any other byte → ISSUE with ir_op=byte, ir_page=0.
- PREFIX
  - addr=pc; rd=1; pc<=pc+1.
  - Further 0x10/0x11 bytes replace ir_page (last one wins) and the block stays in PREFIX.
  - Any other byte → ISSUE with ir_op=byte.
- ISSUE
  - rd=0; ir_valid=1; ir_op/ir_page/ir_pc/pc held stable.
  - On ir_valid&ir_ready → HOLD, and ir_valid drops next cycle.
- HOLD
  - rd=0. On resume: pc<=resume_pc.
  - Next state priority: halt_b=0 → HALT; else vec_req → VEC_HI (vec_sel latched); else FETCH.
- HALT
  - rd=0; halted=1.
  - On halt_b=1: vec_req → VEC_HI, else FETCH.
- All PC/address arithmetic is modulo 2^ADDR_W: pc FFFF+1=0000, and the vector address wraps the same way.
- resume outside HOLD is ignored. vec_req/halt_b are only sampled in HOLD/HALT.
- Asserting reset_b mid-operation aborts any fetch, drops ir_valid immediately and returns to RESET.

## Timing
- Reset values: addr=VEC_BASE+14, rd=0, ir_valid=0, ir_op=0, ir_page=0, ir_pc=0, pc=0, vec_ack=0, halted=0, state RESET.
- Each memory access is one clk cycle; no wait states.
- Reset release → ir_valid high in cycle RESET_IDLE+3. Each prefix byte adds one cycle.
- resume → first FETCH cycle: next cycle. A vector entry adds 2 cycles.
- ir_valid falls the cycle after the handshake. Outputs are stable for the whole time ir_valid=1.

## Configuration
- FETCH6809_PREFIX_EN defined: prefix merging as described above; PREFIX state present.
- Not defined: no PREFIX state. 0x10/0x11 are issued as plain opcodes with ir_page=0 and pc advanced by one; ir_page is tied to 0.

## Test plan
- Reset vector fetch:
  - Stimulus: mem[FFFE]=12, mem[FFFF]=34, mem[1234]=86, RESET_IDLE=1.
  - Response: addr sequence FFFE,FFFE,FFFF,1234; ir_valid in cycle 4 with ir_op=86, ir_page=0, ir_pc=1234, pc=1235; vec_ack stays 0.
- Prefix merge:
  - Stimulus: mem[1234]=10, mem[1235]=10, mem[1236]=8E.
  - Response: ir_page=1, ir_op=8E, ir_pc=1234, pc=1237. With the macro off: ir_op=10, ir_page=0, pc=1235.
- Backpressure:
  - Stimulus: ir_ready=0 for 5 cycles during ISSUE.
  - Response: ir_valid=1, rd=0, and all ir_* outputs and pc unchanged; handshake on the first ir_ready=1; ir_valid=0 next cycle.
- Vector entry:
  - Stimulus: in HOLD, vec_req=1, vec_sel=4, resume pulse, mem[FFF8]=40, mem[FFF9]=00.
  - Response: addr FFF8 then FFF9; vec_ack one cycle; next FETCH addr=4000.
- Halt:
  - Stimulus: halt_b=0 at resume.
  - Response: halted=1, rd=0 indefinitely. Raising halt_b with vec_req=1, vec_sel=6 gives fetches at FFFC/FFFD, then halted=0.
- Wrap and reset mid-op:
  - Stimulus: resume_pc=FFFF, mem[FFFF]=11, mem[0000]=A3.
  - Response: ir_page=2, ir_op=A3, ir_pc=FFFF, pc=0001.
  - Stimulus: pulse reset_b low during PREFIX.
  - Response: ir_valid=0 and addr=FFFE immediately.
